// File: rtl/router_fsm.sv
// router_fsm: Moore sequencer for the 1x3 router datapath.
// Decodes the header address, waits for FIFO drain and steps router_reg.
module router_fsm (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] addr_reg;
    logic [1:0] sel;
    logic [3:0] empty_vec;
    logic [3:0] soft_vec;
    logic       sel_empty;
    logic       sel_soft;
    logic       hdr_ok;

    // Port 3 does not exist: its empty/soft-reset slots read as 0.
    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign sel       = (state == DECODE_ADDRESS) ? data_in : addr_reg;
    assign sel_empty = empty_vec[sel];
    assign sel_soft  = soft_vec[addr_reg];
    assign hdr_ok    = pkt_valid && (data_in != 2'd3);

    // State register; rstn wins over any soft reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the destination port when a valid header is decoded.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_reg <= 2'd0;
        end else if (state == DECODE_ADDRESS && hdr_ok) begin
            addr_reg <= data_in;
        end
    end

    // Next-state logic; a soft reset of the selected port aborts the packet.
    always_comb begin
        state_nxt = state;
        if (state != DECODE_ADDRESS && sel_soft) begin
            state_nxt = DECODE_ADDRESS;
        end else begin
            unique case (state)
                DECODE_ADDRESS: begin
                    if (hdr_ok) begin
                        state_nxt = sel_empty ? LOAD_FIRST_DATA
                                              : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_nxt = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_nxt = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_nxt = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_nxt = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_nxt = LOAD_PARITY;
                    end else begin
                        state_nxt = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_nxt = fifo_full ? FIFO_FULL_STATE
                                          : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty) begin
                        state_nxt = LOAD_FIRST_DATA;
                    end
                end
                default: state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore output decode from the current state only.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b0;
        unique case (state)
            DECODE_ADDRESS: detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state     = 1'b1;
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: busy = 1'b1;
            default: detect_add = 1'b1;
        endcase
    end

endmodule
